// File: rtl/app_err_pkg.sv
// Shared definitions for the approximate-multiplier characterisation blocks:
// FSM state encoding, default widths and a width-generic saturating adder.
package app_err_pkg;

  localparam int unsigned DEF_WIDTH1 = 8;
  localparam int unsigned DEF_WIDTH2 = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  // Working width of sat_add; callers' accumulators must not exceed it.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Unsigned a + b clamped to the all-ones value of a w-bit result.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] s;
    logic [SAT_W:0] lim;
    s = {1'b0, a} + {1'b0, b};
    if (w >= SAT_W) lim = {1'b0, {SAT_W{1'b1}}};
    else            lim = ((SAT_W + 1)'(1) << w) - (SAT_W + 1)'(1);
    return (s > lim) ? lim[SAT_W-1:0] : s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/app_mult_err_acc_if.sv
// Sample stream from the multiplier harness: operands, approximate product
// and a valid/ready handshake.
interface app_mult_err_acc_if
  import app_err_pkg::*;
#(
  parameter int unsigned WIDTH1 = DEF_WIDTH1,
  parameter int unsigned WIDTH2 = DEF_WIDTH2
);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH1-1:0]        A;
  logic [WIDTH2-1:0]        B;
  logic [WIDTH1+WIDTH2-1:0] sum;

  modport master (output in_valid, A, B, sum, input in_ready);
  modport slave  (input in_valid, A, B, sum, output in_ready);

endinterface

// File: rtl/app_err_dist.sv
// Stage S1: registers one operand pair plus approximate product and presents
// the error distance |A*B - sum| with a valid flag on the following cycle.
module app_err_dist
  import app_err_pkg::*;
#(
  parameter int unsigned WIDTH1 = DEF_WIDTH1,
  parameter int unsigned WIDTH2 = DEF_WIDTH2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [WIDTH1-1:0]        a_i,
  input  logic [WIDTH2-1:0]        b_i,
  input  logic [WIDTH1+WIDTH2-1:0] sum_i,
  output logic [WIDTH1+WIDTH2-1:0] ed_o,
  output logic                     ed_valid_o
);

  localparam int unsigned PW = WIDTH1 + WIDTH2;

  logic              s1_valid_q;
  logic [WIDTH1-1:0] a_q;
  logic [WIDTH2-1:0] b_q;
  logic [PW-1:0]     sum_q;
  logic [PW-1:0]     exact;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid_q <= 1'b0;
    else        s1_valid_q <= load_i;
  end

  // NOTE: the payload registers carry no reset; they are only observed while
  // s1_valid_q is set, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (load_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      sum_q <= sum_i;
    end
  end

  // NOTE: every combinational output gets a value on all paths, so no latch.
  always_comb begin
    exact = PW'(a_q) * PW'(b_q);
    ed_o  = (exact >= sum_q) ? (exact - sum_q) : (sum_q - exact);
  end

  assign ed_valid_o = s1_valid_q;

endmodule

// File: rtl/app_mult_err_acc.sv
// Error-statistics accumulator for the approximate unsigned multiplier: counts
// samples, sums and tracks the maximum error distance over a programmed run.
module app_mult_err_acc
  import app_err_pkg::*;
#(
  parameter int unsigned WIDTH1 = DEF_WIDTH1,
  parameter int unsigned WIDTH2 = DEF_WIDTH2,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned ACC_W  = WIDTH1 + WIDTH2 + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         n_samples,
  app_mult_err_acc_if.slave        smp_if,
  output logic                     busy,
  output logic                     done,
  output logic [ACC_W-1:0]         ed_sum,
  output logic [WIDTH1+WIDTH2-1:0] ed_max,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         smp_cnt
);

  localparam int unsigned PW = WIDTH1 + WIDTH2;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] n_lat_q,   n_lat_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] ed_sum_q,  ed_sum_d;
  logic [PW-1:0]    ed_max_q,  ed_max_d;

  logic          in_ready_c;
  logic          xfer;
  logic          busy_c;
  logic          done_c;
  logic [PW-1:0] ed;
  logic          ed_valid;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready_c      = (state_q == RUN) && (smp_cnt_q < n_lat_q);
  assign xfer            = in_ready_c && smp_if.in_valid;
  assign smp_if.in_ready = in_ready_c;

  app_err_dist #(
    .WIDTH1 (WIDTH1),
    .WIDTH2 (WIDTH2)
  ) u_dist (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (xfer),
    .a_i        (smp_if.A),
    .b_i        (smp_if.B),
    .sum_i      (smp_if.sum),
    .ed_o       (ed),
    .ed_valid_o (ed_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_lat_q   <= '0;
      smp_cnt_q <= '0;
      err_cnt_q <= '0;
      ed_sum_q  <= '0;
      ed_max_q  <= '0;
    end else begin
      state_q   <= state_d;
      n_lat_q   <= n_lat_d;
      smp_cnt_q <= smp_cnt_d;
      err_cnt_q <= err_cnt_d;
      ed_sum_q  <= ed_sum_d;
      ed_max_q  <= ed_max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_lat_d   = n_lat_q;
    smp_cnt_d = smp_cnt_q;
    err_cnt_d = err_cnt_q;
    ed_sum_d  = ed_sum_q;
    ed_max_d  = ed_max_q;
    busy_c    = 1'b1;
    done_c    = 1'b0;

    // Stage S2: fold the error distance of the sample held in S1.
    if (ed_valid) begin
      ed_sum_d  = ACC_W'(sat_add(SAT_W'(ed_sum_q), SAT_W'(ed), ACC_W));
      err_cnt_d = err_cnt_q + CNT_W'(ed != '0);
      if (ed > ed_max_q) ed_max_d = ed;
    end

    unique case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (start) begin
          n_lat_d   = n_samples;
          smp_cnt_d = '0;
          err_cnt_d = '0;
          ed_sum_d  = '0;
          ed_max_d  = '0;
          state_d   = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
          if (smp_cnt_d == n_lat_q) state_d = DRAIN;
        end
      end
      // S1 holds exactly the final sample here; it accumulates on this edge.
      DRAIN: state_d = DONE;
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_c;
  assign done    = done_c;
  assign ed_sum  = ed_sum_q;
  assign ed_max  = ed_max_q;
  assign err_cnt = err_cnt_q;
  assign smp_cnt = smp_cnt_q;

endmodule

// File: doc/app_mult_err_acc.md
Name: app_mult_err_acc

Overview:
- Downstream consumer of the approximate unsigned multiplier (app_mult_unsigned family, ports A/B/cin/sum).
- Takes each operand pair plus the multiplier's approximate product.
- Computes the exact product internally and accumulates error statistics over a programmed number of samples: error-distance sum, max error distance, erroneous-sample count.
- Used by the characterisation flow in place of per-vector waveform inspection.

Parameters:
- WIDTH1, 8, operand A width (matches the multiplier's width1)
- WIDTH2, 8, operand B width (matches the multiplier's width2)
- CNT_W, 16, sample counter width
- ACC_W, WIDTH1+WIDTH2+CNT_W, error-distance accumulator width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a measurement run; sampled only in IDLE
- n_samples  in  CNT_W  run length; latched on accepted start
- in_valid  in  1  sample valid
- in_ready  out  1  sample accept; transfer when in_valid && in_ready
- A  in  WIDTH1  operand A
- B  in  WIDTH2  operand B
- sum  in  WIDTH1+WIDTH2  approximate product from the multiplier
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse; final stats valid
- ed_sum  out  ACC_W  sum of |A*B - sum|, saturating
- ed_max  out  WIDTH1+WIDTH2  maximum error distance
- err_cnt  out  CNT_W  number of samples with error distance != 0
- smp_cnt  out  CNT_W  samples accepted this run

Behaviour:
- Reset (synchronous, rst_n=0 at an edge):
  - State goes to IDLE.
  - All outputs, the S1 valid flag and all counters/accumulators go to 0.
  - Applies mid-run: the run is abandoned, no done pulse is produced, and the in-flight sample is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1: clear ed_sum/ed_max/err_cnt/smp_cnt, latch n_samples, then:
    - n_samples==0 → go to DONE;
    - otherwise → go to RUN.
  - Statistics from the previous run are held until the next start.
- RUN:
  - in_ready=1 while smp_cnt < latched n_samples.
  - On each transfer: smp_cnt+1; A, B, sum registered into stage S1 with S1 valid set.
  - The transfer that makes smp_cnt == n_samples moves the FSM to DRAIN; in_ready is 0 from the next cycle.
  - in_valid while in_ready=0 is ignored.
  - start is ignored in every state except IDLE.
- Stage S2, accumulate, on the edge after an S1 load:
  - exact = A*B, full WIDTH1+WIDTH2 bits, unsigned.
  - ed = exact>=sum ? exact-sum : sum-exact.
  - ed_sum += ed, saturating at all-ones.
  - ed_max = max(ed_max, ed).
  - err_cnt += (ed!=0).
- DRAIN: wait for S1 valid to clear, then go to DONE on the same edge as the last accumulation.
- DONE: done=1 for exactly one cycle; busy stays 1; go to IDLE on the next edge.
- Latency:
  - Stats for a sample transferred at edge k are visible after edge k+1.
  - For the last sample, done is high in the cycle after edge k+1.
- Throughput: one sample per cycle; in_ready has no combinational path from in_valid.
- cin is not consumed; approximate-product correctness is judged from sum only.

Decomposition:
- Shared package app_err_pkg holds:
  - FSM state enum (IDLE/RUN/DRAIN/DONE);
  - default width constants;
  - a saturating-add function reused by other characterisation blocks.
- One natural sub-module: app_err_dist (registered S1 + exact product + |difference| → ed, ed_valid). The FSM and accumulators stay in the top.

Test Plan (WIDTH1=WIDTH2=8):
1. Exact inputs, n_samples=3: (3,5,15), (10,10,100), (255,255,65025) → ed_sum=0, ed_max=0, err_cnt=0, smp_cnt=3; done single pulse one cycle after the last stats update.
2. Mixed errors, n_samples=4: (12,12,140), (200,3,590), (7,9,63), (2,2,9) → eds 4, 10, 0, 5; ed_sum=19, ed_max=10, err_cnt=3. This checks absolute value when sum > exact.
3. Back-pressure/gaps, n_samples=2: in_valid toggled 1,0,1,1,1 → exactly 2 transfers; in_ready=0 after the 2nd; extra samples do not alter stats; start pulsed during RUN is ignored.
4. n_samples=0 with start → busy high, done pulse after one cycle, all stats 0, return to IDLE.
5. rst_n=0 for one edge mid-RUN after 2 of 5 samples → all outputs 0, busy=0, no done. A fresh run with n_samples=1, (1,1,0) then gives ed_sum=1, err_cnt=1.
6. Saturation with CNT_W=2, ACC_W=17: n_samples=3, each (255,255,0), ed=65025 → ed_sum=131071 (all ones), ed_max=65025.
